bnn_fmap_serializer: RTL and testbench

- Consumer end of the BNN layer output interface.
- On `start`, snapshots the flattened `out_feature_maps` vector produced by the binary conv layer.
- Streams the snapshot out as fixed-width beats over a valid/ready handshake, LSB-first, for the narrow chip I/O or the next stage.
- Provides busy/done status and a synchronous abort.

---
 rtl/bnn_fmap_serializer.sv | 138 +++++++++++++
 tb/tb_bnn_fmap_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_fmap_serializer.sv
// Purpose: snapshots the flattened BNN feature maps on start and streams them LSB-first as OUT_W-bit beats.
// Latency: first beat valid one cycle after an accepted start; sustains one beat per cycle.
// Backpressure: beat and last are held stable while out_ready is low; abort cancels the frame.
module bnn_fmap_serializer #(
   parameter int BNN_OUT_CHANL = 16,
   parameter int IMG_OUT_SIZE  = 26,
   parameter int OUT_W         = 8
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic [BNN_OUT_CHANL*IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] in_fmaps,
   input  logic                                               start,
   input  logic                                               abort,
   output logic [OUT_W-1:0]                                   out_data,
   output logic                                               out_valid,
   input  logic                                               out_ready,
   output logic                                               out_last,
   output logic                                               busy,
   output logic                                               done
);

   localparam int TOTAL_BITS = BNN_OUT_CHANL * IMG_OUT_SIZE * IMG_OUT_SIZE;
   localparam int NUM_BEATS  = (TOTAL_BITS + OUT_W - 1) / OUT_W;
   localparam int PAD_BITS   = NUM_BEATS * OUT_W;
   localparam int CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   localparam logic [CNT_W-1:0] LAST_BEAT     = CNT_W'(NUM_BEATS - 1);
   localparam logic             FIRST_IS_LAST = (NUM_BEATS == 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                          state;
   state_t                          state_nxt;
   logic [CNT_W-1:0]                beat;
   logic [CNT_W-1:0]                beat_nxt;
   logic [TOTAL_BITS-1:0]           shadow;
   // Snapshot viewed as an array of beats; the tail of the last beat is zero padding.
   logic [NUM_BEATS-1:0][OUT_W-1:0] shadow_beats;
   logic [OUT_W-1:0]                first_beat;
   logic                            xfer;
   logic                            load;
   logic                            advance;
   logic                            finish;

   assign shadow_beats = PAD_BITS'(shadow);
   assign first_beat   = OUT_W'(in_fmaps);
   assign xfer         = out_valid && out_ready;
   assign busy         = (state == SEND);

   // Next-state decode: abort wins over a same-cycle transfer and over start in IDLE.
   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      load      = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = SEND;
               beat_nxt  = '0;
               load      = 1'b1;
            end
         end
         SEND: begin
            if (abort) begin
               state_nxt = IDLE;
               beat_nxt  = '0;
            end else if (xfer && out_last) begin
               state_nxt = IDLE;
               beat_nxt  = '0;
               finish    = 1'b1;
            end else if (xfer) begin
               beat_nxt = beat + CNT_W'(1);
               advance  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            beat_nxt  = '0;
         end
      endcase
   end

   // State and beat counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         beat  <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
      end
   end

   // Snapshot register, written only when a start is accepted so later input changes cannot leak in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
      end else if (load) begin
         shadow <= in_fmaps;
      end
   end

   // Registered output beat: the first beat comes straight from the input being captured,
   // later beats are fetched from the snapshot one index ahead so out_data never depends on out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= first_beat;
         out_last  <= FIRST_IS_LAST;
      end else if (advance) begin
         out_data  <= shadow_beats[beat_nxt];
         out_last  <= (beat_nxt == LAST_BEAT);
      end else if (state_nxt == IDLE) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end
   end

   // One-cycle completion pulse following acceptance of the last beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= finish;
      end
   end

endmodule

// File: tb/tb_bnn_fmap_serializer.sv
// Bench for bnn_fmap_serializer: a small 2x3x3 instance for directed frames and a default-size instance.
// Expected beats are queued by the stimulus and popped by a monitor at every accepted transfer.
// The monitor also checks done timing, busy/valid agreement and beat stability under backpressure.
module tb_bnn_fmap_serializer;

   localparam int NB = 1352;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [17:0]    s_in;
   logic           s_start, s_abort, s_ready, s_valid, s_last, s_busy, s_done;
   logic [7:0]     s_data;

   logic [10815:0] d_in;
   logic           d_start, d_abort, d_ready, d_valid, d_last, d_busy, d_done;
   logic [7:0]     d_data;

   int n_chk = 0;
   int n_fail = 0;
   logic [8:0] exp_q0[$];
   logic [8:0] exp_q1[$];
   int done_cnt0 = 0;
   int done_cnt1 = 0;
   int beats0 = 0;
   int beats1 = 0;

   bnn_fmap_serializer #(.BNN_OUT_CHANL(2), .IMG_OUT_SIZE(3), .OUT_W(8)) u_small (
      .clk(clk), .rst(rst), .in_fmaps(s_in), .start(s_start), .abort(s_abort),
      .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready), .out_last(s_last),
      .busy(s_busy), .done(s_done)
   );

   bnn_fmap_serializer u_dflt (
      .clk(clk), .rst(rst), .in_fmaps(d_in), .start(d_start), .abort(d_abort),
      .out_data(d_data), .out_valid(d_valid), .out_ready(d_ready), .out_last(d_last),
      .busy(d_busy), .done(d_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string t);
      chk({t, " s_valid"}, 32'(s_valid), 32'd0);
      chk({t, " s_last"},  32'(s_last),  32'd0);
      chk({t, " s_busy"},  32'(s_busy),  32'd0);
      chk({t, " s_done"},  32'(s_done),  32'd0);
      chk({t, " s_data"},  32'(s_data),  32'd0);
      chk({t, " d_valid"}, 32'(d_valid), 32'd0);
      chk({t, " d_busy"},  32'(d_busy),  32'd0);
      chk({t, " d_data"},  32'(d_data),  32'd0);
   endtask

   // 18'h2A5C3 split LSB-first into 8-bit beats: C3, A5, then bits 17:16 = 2'b10 padded to 02.
   task automatic push_frame0();
      exp_q0.push_back({1'b0, 8'hC3});
      exp_q0.push_back({1'b0, 8'hA5});
      exp_q0.push_back({1'b1, 8'h02});
   endtask

   task automatic mon_one(input int id, input logic v, r, a, dn, bs, l, input logic [7:0] d,
                          inout logic stall, inout logic [8:0] held, inout logic fin);
      logic [8:0] e;
      string p;
      p = (id == 0) ? "small" : "dflt";
      chk({p, " done_timing"}, 32'(dn), 32'(fin));
      chk({p, " busy_vs_valid"}, 32'(bs), 32'(v));
      if (stall) begin
         chk({p, " hold_valid"}, 32'(v), 32'd1);
         chk({p, " hold_beat"}, 32'({l, d}), 32'(held));
      end
      stall = 1'b0;
      fin   = 1'b0;
      if (v && r && !a) begin
         if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s extra_beat: got 0x%0h with nothing expected", p, {l, d});
         end else begin
            e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk({p, " beat"}, 32'({l, d}), 32'(e));
         end
         if (id == 0) beats0++;
         else beats1++;
         fin = l;
      end else if (v && !r && !a) begin
         stall = 1'b1;
         held  = {l, d};
      end
      if (dn) begin
         if (id == 0) done_cnt0++;
         else done_cnt1++;
      end
   endtask

   task automatic monitor();
      logic st0 = 1'b0, st1 = 1'b0, f0 = 1'b0, f1 = 1'b0;
      logic [8:0] h0 = '0, h1 = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            st0 = 1'b0; st1 = 1'b0; f0 = 1'b0; f1 = 1'b0;
         end else begin
            mon_one(0, s_valid, s_ready, s_abort, s_done, s_busy, s_last, s_data, st0, h0, f0);
            mon_one(1, d_valid, d_ready, d_abort, d_done, d_busy, d_last, d_data, st1, h1, f1);
         end
      end
   endtask

   task automatic wait_done(input int id, input int target, input string nm, input int budget);
      int cyc = 0;
      while (((id == 0) ? done_cnt0 : done_cnt1) < target && cyc < budget) begin
         tick();
         cyc++;
      end
      chk({nm, " done_count"}, 32'((id == 0) ? done_cnt0 : done_cnt1), 32'(target));
   endtask

   initial begin
      int b;
      logic restarted;
      rst = 1'b0;
      s_in = '0; s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
      d_in = '1; d_start = 1'b0; d_abort = 1'b0; d_ready = 1'b0;
      fork
         monitor();
      join_none
      #1 rst = 1'b1;
      #2;
      chk_idle("reset");
      tick(); tick();
      rst = 1'b0;
      tick();
      chk_idle("post_reset");

      // Basic frame, out_ready held high.
      s_in = 18'h2A5C3;
      push_frame0();
      chk("basic pre_valid", 32'(s_valid), 32'd0);
      s_start = 1'b1; tick(); s_start = 1'b0;
      chk("basic start_latency", 32'(s_valid), 32'd1);
      chk("basic first_beat", 32'(s_data), 32'hC3);
      wait_done(0, 1, "basic", 50);
      tick();
      chk("basic busy_after", 32'(s_busy), 32'd0);

      // Backpressure while 0xA5 is presented.
      b = beats0;
      push_frame0();
      s_start = 1'b1; tick(); s_start = 1'b0;
      tick();
      chk("bp second_beat", 32'(s_data), 32'hA5);
      s_ready = 1'b0;
      repeat (3) tick();
      chk("bp held_data", 32'(s_data), 32'hA5);
      chk("bp held_valid", 32'(s_valid), 32'd1);
      s_ready = 1'b1;
      wait_done(0, 2, "bp", 50);
      chk("bp beat_total", 32'(beats0 - b), 32'd3);

      // Snapshot isolation and start ignored mid-frame.
      b = beats0;
      push_frame0();
      s_start = 1'b1; tick(); s_start = 1'b0;
      s_in = '0;
      tick();
      s_start = 1'b1; tick(); s_start = 1'b0;
      wait_done(0, 3, "snap", 50);
      repeat (4) tick();
      chk("snap single_done", 32'(done_cnt0), 32'd3);
      chk("snap idle_valid", 32'(s_valid), 32'd0);
      chk("snap beat_total", 32'(beats0 - b), 32'd3);
      s_in = 18'h2A5C3;

      // Abort during beat 1 with out_ready high: 0xA5 is discarded.
      b = beats0;
      exp_q0.push_back({1'b0, 8'hC3});
      s_start = 1'b1; tick(); s_start = 1'b0;
      tick();
      s_abort = 1'b1; tick(); s_abort = 1'b0;
      chk("abort valid", 32'(s_valid), 32'd0);
      chk("abort busy", 32'(s_busy), 32'd0);
      chk("abort data", 32'(s_data), 32'd0);
      repeat (3) tick();
      chk("abort no_done", 32'(done_cnt0), 32'd3);
      chk("abort beat_total", 32'(beats0 - b), 32'd1);
      s_abort = 1'b1; s_start = 1'b1; tick(); s_abort = 1'b0; s_start = 1'b0;
      chk("abort idle_blocks_start", 32'(s_valid), 32'd0);
      chk("abort idle_busy", 32'(s_busy), 32'd0);
      tick();
      push_frame0();
      s_start = 1'b1; tick(); s_start = 1'b0;
      chk("abort restart_beat", 32'(s_data), 32'hC3);
      wait_done(0, 4, "abort_restart", 50);

      // Asynchronous reset in the middle of a frame.
      exp_q0.push_back({1'b0, 8'hC3});
      s_start = 1'b1; tick(); s_start = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("midrst valid", 32'(s_valid), 32'd0);
      chk("midrst last", 32'(s_last), 32'd0);
      chk("midrst busy", 32'(s_busy), 32'd0);
      chk("midrst done", 32'(s_done), 32'd0);
      chk("midrst data", 32'(s_data), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      tick(); tick();
      chk_idle("midrst_release");
      chk("small queue_empty", 32'(exp_q0.size()), 32'd0);

      // Default geometry: all-ones maps, random backpressure, restart in the done cycle.
      for (int i = 0; i < NB; i++) exp_q1.push_back({(i == NB - 1), 8'hFF});
      d_ready = 1'($urandom_range(0, 1));
      d_start = 1'b1; tick(); d_start = 1'b0;
      chk("dflt start_latency", 32'(d_valid), 32'd1);
      restarted = 1'b0;
      for (int cyc = 0; cyc < 20000 && done_cnt1 < 2; cyc++) begin
         d_start = 1'b0;
         if (d_done && !restarted) begin
            for (int i = 0; i < NB; i++) exp_q1.push_back({(i == NB - 1), 8'hFF});
            d_start = 1'b1;
            restarted = 1'b1;
         end
         d_ready = 1'($urandom_range(0, 1));
         tick();
         if (d_start) chk("dflt restart_in_done_cycle", 32'(d_valid), 32'd1);
      end
      d_start = 1'b0;
      d_ready = 1'b0;
      repeat (3) tick();
      chk("dflt done_count", 32'(done_cnt1), 32'd2);
      chk("dflt beat_total", 32'(beats1), 32'(2 * NB));
      chk("dflt queue_empty", 32'(exp_q1.size()), 32'd0);
      chk("dflt idle_valid", 32'(d_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
